// File: rtl/red_pitaya_fads_event_fifo.sv
// Event FIFO for FADS droplet records, read and popped over the sys bus.
// Define FADS_EVENT_TIMESTAMP_EN to store a free-running cycle timestamp with each entry.
module red_pitaya_fads_event_fifo #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned DWT        = 14
)(
   input  logic            adc_clk_i,
   input  logic            adc_rst_i,
   input  logic            evt_valid_i,
   input  logic [31:0]     evt_width_i,
   input  logic [DWT-1:0]  evt_intensity_i,
   input  logic            evt_sorted_i,
   input  logic [31:0]     sys_addr,
   input  logic [31:0]     sys_wdata,
   input  logic [3:0]      sys_sel,
   input  logic            sys_wen,
   input  logic            sys_ren,
   output logic [31:0]     sys_rdata,
   output logic            sys_err,
   output logic            sys_ack
);

   localparam int unsigned         DEPTH      = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

   localparam logic [19:0] ADDR_STATUS = 20'h00000;
   localparam logic [19:0] ADDR_OVFCNT = 20'h00004;
   localparam logic [19:0] ADDR_CTRL   = 20'h00008;
   localparam logic [19:0] ADDR_WIDTH  = 20'h00010;
   localparam logic [19:0] ADDR_INTEN  = 20'h00014;
   localparam logic [19:0] ADDR_TSTAMP = 20'h00018;
   localparam logic [19:0] ADDR_POP    = 20'h0001C;

   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic [31:0]           ovf_cnt_q, ovf_cnt_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  ack_q;
   logic                  err_q;

   logic [31:0]           width_mem [DEPTH];
   logic [DWT-1:0]        inten_mem [DEPTH];
   logic [DEPTH-1:0]      sorted_mem;

   logic [19:0] addr;
   logic        ctrl_wr, flush, clr_ovf, pop_req;
   logic        empty, full;
   logic        do_push, do_pop, ovf_evt;
   logic [31:0] head_width;
   logic [13:0] head_inten;
   logic        head_sorted;
   logic [31:0] head_tstamp;

   logic unused_bits;
   assign unused_bits = ^{sys_sel, sys_addr[31:20], sys_wdata[31:2]};

   assign addr    = sys_addr[19:0];
   assign ctrl_wr = sys_wen && (addr == ADDR_CTRL);
   assign flush   = ctrl_wr && sys_wdata[0];
   assign clr_ovf = ctrl_wr && sys_wdata[1];
   assign pop_req = sys_wen && (addr == ADDR_POP);

   assign empty = (count_q == '0);
   assign full  = (count_q == COUNT_FULL);

   // Flush overrides both push and pop; a pop on a full FIFO frees the slot for a same-cycle push.
   assign do_pop  = pop_req && !flush && !empty;
   assign do_push = evt_valid_i && !flush && (!full || do_pop);
   assign ovf_evt = evt_valid_i && !flush && full && !do_pop;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      ovf_cnt_d = ovf_cnt_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
            default: count_d = count_q;
         endcase
      end

      if (clr_ovf) begin
         ovf_d     = 1'b0;
         ovf_cnt_d = '0;
      end else if (ovf_evt) begin
         ovf_d = 1'b1;
         if (ovf_cnt_q != 32'hFFFF_FFFF) ovf_cnt_d = ovf_cnt_q + 32'd1;
      end
   end

`ifdef FADS_EVENT_TIMESTAMP_EN
   logic [31:0] tstamp_q;
   logic [31:0] tstamp_mem [DEPTH];

   always_ff @(posedge adc_clk_i) begin
      if (adc_rst_i) tstamp_q <= '0;
      else           tstamp_q <= tstamp_q + 32'd1;
   end

   always_ff @(posedge adc_clk_i) begin
      if (!adc_rst_i && do_push) tstamp_mem[wr_ptr_q] <= tstamp_q;
   end

   assign head_tstamp = empty ? 32'd0 : tstamp_mem[rd_ptr_q];
`else
   assign head_tstamp = 32'd0;
`endif

   // Storage has no reset; validity is carried entirely by the pointers and count.
   always_ff @(posedge adc_clk_i) begin
      if (!adc_rst_i && do_push) begin
         width_mem[wr_ptr_q]  <= evt_width_i;
         inten_mem[wr_ptr_q]  <= evt_intensity_i;
         sorted_mem[wr_ptr_q] <= evt_sorted_i;
      end
   end

   assign head_width  = empty ? 32'd0 : width_mem[rd_ptr_q];
   assign head_inten  = empty ? 14'd0 : 14'($signed(inten_mem[rd_ptr_q]));
   assign head_sorted = empty ? 1'b0  : sorted_mem[rd_ptr_q];

   always_comb begin
      rdata_d = '0;
      if (sys_ren) begin
         case (addr)
            ADDR_STATUS: rdata_d = {13'b0, ovf_q, full, empty, 16'(count_q)};
            ADDR_OVFCNT: rdata_d = ovf_cnt_q;
            ADDR_WIDTH:  rdata_d = head_width;
            ADDR_INTEN:  rdata_d = {head_sorted, 17'b0, head_inten};
            ADDR_TSTAMP: rdata_d = head_tstamp;
            default:     rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge adc_clk_i) begin
      if (adc_rst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         ovf_cnt_q <= '0;
         rdata_q   <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         ovf_cnt_q <= ovf_cnt_d;
         rdata_q   <= rdata_d;
         ack_q     <= sys_wen || sys_ren;
         err_q     <= 1'b0;
      end
   end

   assign sys_rdata = rdata_q;
   assign sys_ack   = ack_q;
   assign sys_err   = err_q;

endmodule

// File: tb/tb_red_pitaya_fads_event_fifo.sv
// Randomised and directed bench for red_pitaya_fads_event_fifo against a queue-based model.
module tb_red_pitaya_fads_event_fifo;

   localparam int unsigned DEPTH_LOG2 = 4;
   localparam int unsigned DEPTH      = 16;
   localparam int unsigned DWT        = 14;

   logic           clk = 1'b0;
   logic           rst;
   logic           evt_valid, evt_sorted;
   logic [31:0]    evt_width;
   logic [DWT-1:0] evt_intensity;
   logic [31:0]    sys_addr, sys_wdata, sys_rdata;
   logic [3:0]     sys_sel;
   logic           sys_wen, sys_ren, sys_err, sys_ack;

   always #5 clk = ~clk;

   red_pitaya_fads_event_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .DWT        (DWT)
   ) dut (
      .adc_clk_i       (clk),
      .adc_rst_i       (rst),
      .evt_valid_i     (evt_valid),
      .evt_width_i     (evt_width),
      .evt_intensity_i (evt_intensity),
      .evt_sorted_i    (evt_sorted),
      .sys_addr        (sys_addr),
      .sys_wdata       (sys_wdata),
      .sys_sel         (sys_sel),
      .sys_wen         (sys_wen),
      .sys_ren         (sys_ren),
      .sys_rdata       (sys_rdata),
      .sys_err         (sys_err),
      .sys_ack         (sys_ack)
   );

   typedef struct packed {
      logic [31:0] w;
      logic [13:0] inten;
      logic        s;
      logic [31:0] ts;
   } ev_t;

   ev_t         q[$];
   logic        m_ovf;
   logic [31:0] m_ovf_cnt, m_tsc;
   logic        pend_ack, exp_ack;
   logic [31:0] pend_rdata, exp_rdata;
   bit          chk_en;
   int          checks, fails;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] r;
      int n;
      n = q.size();
      r = 32'd0;
      case (a[19:0])
         20'h00: r = {13'b0, m_ovf, (n == DEPTH), (n == 0), 16'(n)};
         20'h04: r = m_ovf_cnt;
         20'h10: if (n > 0) r = q[0].w;
         20'h14: if (n > 0) r = {q[0].s, 17'b0, q[0].inten};
`ifdef FADS_EVENT_TIMESTAMP_EN
         20'h18: if (n > 0) r = q[0].ts;
`endif
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   // Advances the model by one clock edge using the inputs currently applied.
   task automatic m_step();
      bit   flush, clr, pop_req, popped, ovf_evt;
      ev_t  e;
      if (rst) begin
         q.delete();
         m_ovf      = 1'b0;
         m_ovf_cnt  = 32'd0;
         m_tsc      = 32'd0;
         pend_ack   = 1'b0;
         pend_rdata = 32'd0;
      end else begin
         pend_ack   = sys_wen | sys_ren;
         pend_rdata = sys_ren ? m_read(sys_addr) : 32'd0;
         flush   = sys_wen && (sys_addr[19:0] == 20'h08) && sys_wdata[0];
         clr     = sys_wen && (sys_addr[19:0] == 20'h08) && sys_wdata[1];
         pop_req = sys_wen && (sys_addr[19:0] == 20'h1C);
         ovf_evt = 1'b0;
         if (flush) begin
            q.delete();
         end else begin
            popped = pop_req && (q.size() > 0);
            if (evt_valid && q.size() == DEPTH && !popped) ovf_evt = 1'b1;
            if (popped) void'(q.pop_front());
            if (evt_valid && !ovf_evt) begin
               e.w     = evt_width;
               e.inten = 14'(evt_intensity);
               e.s     = evt_sorted;
               e.ts    = m_tsc;
               q.push_back(e);
            end
         end
         if (clr) begin
            m_ovf     = 1'b0;
            m_ovf_cnt = 32'd0;
         end else if (ovf_evt) begin
            m_ovf = 1'b1;
            if (m_ovf_cnt != 32'hFFFF_FFFF) m_ovf_cnt = m_ovf_cnt + 32'd1;
         end
         m_tsc = m_tsc + 32'd1;
      end
   endtask

   task automatic tick();
      m_step();
      @(posedge clk);
      #1;
      exp_ack   = pend_ack;
      exp_rdata = pend_rdata;
   endtask

   task automatic idle_inputs();
      evt_valid = 1'b0; evt_width = '0; evt_intensity = '0; evt_sorted = 1'b0;
      sys_addr = '0; sys_wdata = '0; sys_sel = 4'hF; sys_wen = 1'b0; sys_ren = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      sys_ren = 1'b1; sys_addr = a;
      tick();
      sys_ren = 1'b0; sys_addr = '0;
      d = sys_rdata;
   endtask

   task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      check(name, d, exp);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      sys_wen = 1'b1; sys_addr = a; sys_wdata = d;
      tick();
      sys_wen = 1'b0; sys_addr = '0; sys_wdata = '0;
   endtask

   task automatic push(input logic [31:0] w, input logic [DWT-1:0] i, input logic s);
      evt_valid = 1'b1; evt_width = w; evt_intensity = i; evt_sorted = s;
      tick();
      evt_valid = 1'b0;
   endtask

   // Every cycle: bus outputs against the model's registered response.
   always @(negedge clk) begin
      if (chk_en) begin
         check("ack", {31'b0, sys_ack}, {31'b0, exp_ack});
         check("rdata", sys_rdata, exp_rdata);
         check("err", {31'b0, sys_err}, 32'd0);
      end
   end

   initial begin
      logic [31:0] ts1, ts2, a;
      int unsigned r, push_pct, pop_pct;
      checks = 0; fails = 0; chk_en = 1'b0;
      idle_inputs();
      rst = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;

      rd_chk("reset_status", 32'h00, 32'h0001_0000);
      rd_chk("reset_ovfcnt", 32'h04, 32'h0);

      push(32'd100, -14'sd5, 1'b1);
      rd_chk("one_status", 32'h00, 32'h0000_0001);
      rd_chk("one_width", 32'h10, 32'd100);
      rd_chk("one_inten", 32'h14, 32'h8000_3FFB);
      wr(32'h1C, 32'h0);
      rd_chk("popped_status", 32'h00, 32'h0001_0000);
      rd_chk("empty_head_width", 32'h10, 32'h0);
      rd_chk("empty_head_inten", 32'h14, 32'h0);

      for (int i = 1; i <= 17; i++) push(32'(i), 14'(i), i[0]);
      rd_chk("full_status", 32'h00, 32'h0006_0010);
      rd_chk("full_ovfcnt", 32'h04, 32'd1);
      rd_chk("full_head", 32'h10, 32'd1);

      evt_valid = 1'b1; evt_width = 32'd18; sys_wen = 1'b1; sys_addr = 32'h1C;
      tick();
      idle_inputs();
      rd_chk("fullpp_status", 32'h00, 32'h0006_0010);
      rd_chk("fullpp_ovfcnt", 32'h04, 32'd1);
      rd_chk("fullpp_head", 32'h10, 32'd2);

      wr(32'h08, 32'h3);
      rd_chk("flush_status", 32'h00, 32'h0001_0000);
      rd_chk("flush_ovfcnt", 32'h04, 32'h0);
      wr(32'h1C, 32'h0);
      rd_chk("emptypop_status", 32'h00, 32'h0001_0000);
      evt_valid = 1'b1; evt_width = 32'd55; sys_wen = 1'b1; sys_addr = 32'h1C;
      tick();
      idle_inputs();
      rd_chk("emptypp_status", 32'h00, 32'h0000_0001);
      rd_chk("emptypp_head", 32'h10, 32'd55);

      push(32'd56, 14'd7, 1'b0);
      push(32'd57, 14'd8, 1'b1);
      rd_chk("three_status", 32'h00, 32'h0000_0003);
      evt_valid = 1'b1; evt_width = 32'd58; sys_wen = 1'b1; sys_addr = 32'h08; sys_wdata = 32'h3;
      tick();
      idle_inputs();
      rd_chk("flushpush_status", 32'h00, 32'h0001_0000);
      rd_chk("flushpush_ovfcnt", 32'h04, 32'h0);

      // Two pushes exactly 15 edges apart after a fresh reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      push(32'd1, 14'd1, 1'b0);
      rd(32'h18, ts1);
      wr(32'h1C, 32'h0);
      for (int i = 0; i < 12; i++) tick();
      push(32'd2, 14'd2, 1'b0);
      rd(32'h18, ts2);
`ifdef FADS_EVENT_TIMESTAMP_EN
      check("tstamp_delta", ts2 - ts1, 32'd15);
`else
      check("tstamp_first", ts1, 32'd0);
      check("tstamp_second", ts2, 32'd0);
`endif

      for (int i = 0; i < 3000; i++) begin
         case ((i / 250) % 3)
            0:       begin push_pct = 80; pop_pct = 15; end
            1:       begin push_pct = 20; pop_pct = 45; end
            default: begin push_pct = 50; pop_pct = 30; end
         endcase
         idle_inputs();
         rst           = ($urandom_range(0, 799) == 0);
         evt_valid     = ($urandom_range(0, 99) < push_pct);
         evt_width     = $urandom;
         evt_intensity = DWT'($urandom);
         evt_sorted    = $urandom_range(0, 1) == 1;
         sys_sel       = 4'($urandom);
         r = $urandom_range(0, 99);
         case ($urandom_range(0, 7))
            0: a = 32'h00;  1: a = 32'h04;  2: a = 32'h10;  3: a = 32'h14;
            4: a = 32'h18;  5: a = 32'h0010_0000; 6: a = 32'h20; default: a = 32'h0;
         endcase
         if (r < 35) begin
            sys_ren = 1'b1; sys_addr = a;
         end else if (r < 35 + pop_pct) begin
            sys_wen = 1'b1; sys_addr = ($urandom_range(0, 3) == 0) ? 32'h0030_001C : 32'h1C;
            sys_wdata = $urandom;
            sys_ren = ($urandom_range(0, 9) == 0);
         end else if (r < 37 + pop_pct) begin
            sys_wen = 1'b1; sys_addr = ($urandom_range(0, 1) == 0) ? 32'h08 : 32'h0010_0008;
            sys_wdata = {$urandom_range(0, 'h3FFF_FFFF), 2'($urandom)};
         end else if (r < 40 + pop_pct) begin
            sys_wen = 1'b1; sys_addr = a; sys_wdata = $urandom;
         end
         tick();
      end
      idle_inputs();
      rst = 1'b0;

      for (int i = 0; i < 20; i++) push(32'(i + 200), 14'(i), 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rd_chk("midreset_status", 32'h00, 32'h0001_0000);
      rd_chk("midreset_ovfcnt", 32'h04, 32'h0);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/red_pitaya_fads_event_fifo.md
RED_PITAYA_FADS_EVENT_FIFO -- requirements
Module: red_pitaya_fads_event_fifo

Interface
REQ-001 Parameter: DEPTH_LOG2, default 4, FIFO depth = 2^DEPTH_LOG2 entries.
REQ-002 Parameter: DWT, default 14, droplet intensity width.
REQ-003 adc_clk_i  input  1  ADC clock; single clock domain for all logic.
REQ-004 adc_rst_i  input  1  reset; synchronous, active-high.
REQ-005 evt_valid_i  input  1  one-cycle strobe from the FADS detector at droplet evaluation.
REQ-006 evt_width_i  input  32  droplet width in clock cycles.
REQ-007 evt_intensity_i  input  DWT  signed peak droplet intensity.
REQ-008 evt_sorted_i  input  1  droplet was sorted (positive, sorting enabled).
REQ-009 sys_addr  input  32  bus address; only [19:0] is decoded.
REQ-010 sys_wdata  input  32  bus write data.
REQ-011 sys_sel  input  4  byte select; ignored, full-word access only.
REQ-012 sys_wen  input  1  bus write enable.
REQ-013 sys_ren  input  1  bus read enable.
REQ-014 sys_rdata  output  32  bus read data.
REQ-015 sys_err  output  1  bus error; constant 0 after reset.
REQ-016 sys_ack  output  1  bus acknowledge.

Function
REQ-017 Push: each adc_clk_i edge with evt_valid_i=1 and FIFO not full SHALL store {width, intensity, sorted} at the write pointer, increment write pointer mod depth and increment count.
REQ-018 Overflow: a push while full and without a same-cycle pop SHALL discard the event, set sticky overflow flag, and increment overflow_cnt (32 bit, saturating at 0xFFFFFFFF).
REQ-019 Pop: a bus write to 0x1C SHALL advance the read pointer and decrement count; pop while empty SHALL be a no-op.
REQ-020 Simultaneous push and pop: when full, both SHALL occur, count unchanged, no overflow; when empty, push SHALL be accepted and pop ignored.
REQ-021 Pointers SHALL be DEPTH_LOG2 bits and wrap naturally; count SHALL be DEPTH_LOG2+1 bits (0..2^DEPTH_LOG2).
REQ-022 A pushed event SHALL be visible in the head registers starting the cycle after the push edge.
REQ-023 Register map (read): 0x00 status {13'b0, overflow, full, empty, 16-bit count zero-extended}; 0x04 overflow_cnt; 0x10 head width; 0x14 head {sorted at bit 31, 17'b0, intensity at [13:0]}; 0x18 head timestamp; other addresses read 0.
REQ-024 Head reads SHALL NOT pop; reading while empty SHALL return 0 at 0x10/0x14/0x18.
REQ-025 Control write 0x08: bit0=1 flush (pointers and count to 0); bit1=1 clear overflow flag and overflow_cnt; both bits may be set together.
REQ-026 Flush coinciding with push or pop: flush SHALL win; the event is dropped and not counted as overflow.
REQ-027 sys_ack SHALL assert exactly one cycle after any cycle with sys_wen or sys_ren, for any address; sys_rdata SHALL be registered with ack and reflect state sampled in the request cycle.

Reset
REQ-028 While adc_rst_i=1 at an edge: pointers, count, overflow flag, overflow_cnt, timestamp counter, sys_ack, sys_err and sys_rdata SHALL go to 0; stored FIFO contents need not be cleared.
REQ-029 Reset mid-operation SHALL discard all queued events; status after reset reads 0x00010000 (empty).

Configuration
REQ-030 Macro FADS_EVENT_TIMESTAMP_EN: when defined, a free-running 32-bit cycle counter (wrapping) SHALL be stored per entry at push and returned at 0x18.
REQ-031 Without FADS_EVENT_TIMESTAMP_EN: no counter or timestamp storage is synthesised, and 0x18 SHALL read 0.

Verification
REQ-032 Reset, then push width=100, intensity=-5, sorted=1 -> status 0x00000001; 0x10=100; 0x14=0x80003FFB; write 0x1C -> status 0x00010000.
REQ-033 Push 17 events at DEPTH_LOG2=4 -> status 0x00060010 (full + overflow, count 16), overflow_cnt=1, head = first event.
REQ-034 When full, push and pop on the same cycle -> count stays 16, overflow_cnt unchanged, head = second event.
REQ-035 Pop when empty, and push+pop on the same cycle when empty -> first gives count 0; second gives count 1 with the pushed event at head.
REQ-036 3 events queued, then write 0x08=0x3 together with evt_valid_i -> status 0x00010000, overflow_cnt=0.
REQ-037 With FADS_EVENT_TIMESTAMP_EN, push at cycles 10 and 25 after reset -> successive 0x18 reads differ by 15; without the macro 0x18 reads 0.
